// File: rtl/acc_pkg.sv
// Shared constants and state encodings for the acc_top APB loader.
package acc_pkg;

  localparam logic [12:0] ACC_EN_ADDR     = 13'd0;
  localparam logic [12:0] ACC_LOAD_A_ADDR = 13'd1;
  localparam logic [12:0] ACC_LOAD_X_ADDR = 13'd2;

  localparam logic [31:0] ACC_EN_VALUE  = 32'd1;
  localparam logic [31:0] ACC_END_VALUE = 32'd0;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_EN_SETUP,
    LD_EN_ACCESS,
    LD_A_WAIT,
    LD_A_SETUP,
    LD_A_ACCESS,
    LD_X_WAIT,
    LD_X_SETUP,
    LD_X_ACCESS,
    LD_FIN
  } ld_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_ACCESS
  } wr_state_e;

endpackage

// File: rtl/acc_apb_wr.sv
// Single-transfer APB write engine: one req launches SETUP then ACCESS,
// cpl/cpl_err pulse in the cycle PREADY completes the transfer.
module acc_apb_wr #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic              cpl,
  output logic              cpl_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  import acc_pkg::*;

  wr_state_e state, state_nxt;

  // Phase register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= WR_IDLE;
    else        state <= state_nxt;
  end

  // Address/data captured at launch and held through ACCESS wait states.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (req && state == WR_IDLE) begin
      PADDR  <= addr;
      PWDATA <= data;
    end
  end

  // Next phase: SETUP is always one cycle, ACCESS lasts until PREADY.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WR_IDLE:   if (req) state_nxt = WR_SETUP;
      WR_SETUP:  state_nxt = WR_ACCESS;
      WR_ACCESS: if (PREADY) state_nxt = WR_IDLE;
      default:   state_nxt = WR_IDLE;
    endcase
  end

  assign PSEL    = (state != WR_IDLE);
  assign PENABLE = (state == WR_ACCESS);
  assign PWRITE  = PSEL;
  assign cpl     = (state == WR_ACCESS) && PREADY;
  assign cpl_err = cpl && PSLVERR;

endmodule

// File: rtl/acc_apb_loader.sv
// APB master front end for acc_top: per job, one enable write followed by
// A_WORDS coefficient writes and X_WORDS input writes taken from a stream.
module acc_apb_loader #(
  parameter int unsigned A_WORDS = 9,
  parameter int unsigned X_WORDS = 784,
  parameter int unsigned ADDR_W  = 13
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  import acc_pkg::*;

  localparam int unsigned CNT_W = $clog2(X_WORDS + 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_WORDS - 1);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_WORDS - 1);

  ld_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_nxt;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_cpl;
  logic              wr_cpl_err;

  acc_apb_wr #(
    .ADDR_W (ADDR_W)
  ) u_wr (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .req     (wr_req),
    .addr    (wr_addr),
    .data    (wr_data),
    .cpl     (wr_cpl),
    .cpl_err (wr_cpl_err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  // Loader state, word counter and sticky error flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= LD_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Sequencing: the engine is launched on the transition into each SETUP
  // state, so loader SETUP/ACCESS states track the engine phases exactly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state)
      LD_IDLE: begin
        if (start) begin
          state_nxt = LD_EN_SETUP;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          wr_req    = 1'b1;
          wr_addr   = ADDR_W'(ACC_EN_ADDR);
          wr_data   = ACC_EN_VALUE;
        end
      end
      LD_EN_SETUP: state_nxt = LD_EN_ACCESS;
      LD_EN_ACCESS: begin
        if (wr_cpl_err) begin
          err_nxt   = 1'b1;
          state_nxt = LD_FIN;
        end else if (wr_cpl) begin
          state_nxt = LD_A_WAIT;
        end
      end
      LD_A_WAIT: begin
        if (s_valid) begin
          wr_req    = 1'b1;
          wr_addr   = ADDR_W'(ACC_LOAD_A_ADDR);
          wr_data   = s_data;
          state_nxt = LD_A_SETUP;
        end
      end
      LD_A_SETUP: state_nxt = LD_A_ACCESS;
      LD_A_ACCESS: begin
        if (wr_cpl_err) begin
          err_nxt   = 1'b1;
          state_nxt = LD_FIN;
        end else if (wr_cpl) begin
          if (cnt == A_LAST) begin
            cnt_nxt   = '0;
            state_nxt = LD_X_WAIT;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = LD_A_WAIT;
          end
        end
      end
      LD_X_WAIT: begin
        if (s_valid) begin
          wr_req    = 1'b1;
          wr_addr   = ADDR_W'(ACC_LOAD_X_ADDR);
          wr_data   = s_data;
          state_nxt = LD_X_SETUP;
        end
      end
      LD_X_SETUP: state_nxt = LD_X_ACCESS;
      LD_X_ACCESS: begin
        if (wr_cpl_err) begin
          err_nxt   = 1'b1;
          state_nxt = LD_FIN;
        end else if (wr_cpl) begin
          if (cnt == X_LAST) begin
            state_nxt = LD_FIN;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = LD_X_WAIT;
          end
        end
      end
      LD_FIN:  state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign busy    = (state != LD_IDLE);
  assign done    = (state == LD_FIN);
  assign s_ready = (state == LD_A_WAIT) || (state == LD_X_WAIT);

endmodule

// File: tb/tb_acc_apb_loader.sv
// Directed bench for acc_apb_loader: a small instance (A=2, X=3) for the
// protocol scenarios and a default-sized instance for the full job.
module tb_acc_apb_loader;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  // Small instance
  logic        start = 1'b0;
  logic        busy, done, err, s_valid, s_ready;
  logic [31:0] s_data;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable, pready, pslverr;

  logic sv_en = 1'b1;
  logic ws_mode = 1'b0;
  logic starve = 1'b0;
  logic slverr_en = 1'b0;

  acc_apb_loader #(
    .A_WORDS (2),
    .X_WORDS (3),
    .ADDR_W  (13)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PWRITE  (pwrite),
    .PSEL    (psel),
    .PENABLE (penable),
    .PREADY  (pready),
    .PSLVERR (pslverr)
  );

  // Default instance
  logic        d_start = 1'b0;
  logic        d_busy, d_done, d_err, d_s_ready;
  logic [31:0] d_s_data;
  logic [12:0] d_paddr;
  logic [31:0] d_pwdata;
  logic        d_pwrite, d_psel, d_penable;

  acc_apb_loader dut_d (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .start   (d_start),
    .busy    (d_busy),
    .done    (d_done),
    .err     (d_err),
    .s_valid (1'b1),
    .s_ready (d_s_ready),
    .s_data  (d_s_data),
    .PADDR   (d_paddr),
    .PWDATA  (d_pwdata),
    .PWRITE  (d_pwrite),
    .PSEL    (d_psel),
    .PENABLE (d_penable),
    .PREADY  (1'b1),
    .PSLVERR (1'b0)
  );

  // Stream source and slave behaviour for the small instance
  logic [31:0] vec [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
  int unsigned sidx = 0;
  int gap = 0;
  int ws_cnt = 0;
  logic in_acc = 1'b0;

  assign s_data  = (sidx < 5) ? vec[sidx] : 32'hDEAD_BEEF;
  assign s_valid = sv_en && !(starve && sidx == 2 && gap < 5);
  assign pready  = !ws_mode || (ws_cnt >= 2);
  assign pslverr = slverr_en && psel && penable && paddr == 13'd1 && pwdata == 32'h22;

  int wa[$];
  int wd[$];
  int unstable = 0, b2b = 0, wait_cycles = 0, hold_cycles = 0;
  logic [12:0] lat_a = '0;
  logic [31:0] lat_d = '0;
  logic prev_cpl = 1'b0;
  logic hs;

  always begin
    @(negedge HCLK);
    hs = s_valid && s_ready;
    if (psel && !penable) begin
      lat_a = paddr;
      lat_d = pwdata;
      if (prev_cpl) b2b++;
    end
    if (psel && penable) begin
      if (paddr !== lat_a || pwdata !== lat_d) unstable++;
      if (!pready) wait_cycles++;
      else begin
        wa.push_back(int'(paddr));
        wd.push_back(int'(pwdata));
      end
    end
    if (busy && !s_valid && s_ready && !psel) hold_cycles++;
    prev_cpl = psel && penable && pready;
    @(posedge HCLK);
    #1;
    if (starve && sidx == 2 && gap < 5) gap++;
    if (hs && !HRESET) sidx++;
    if (psel && penable) begin
      ws_cnt = in_acc ? ws_cnt + 1 : 0;
      in_acc = 1'b1;
    end else begin
      ws_cnt = 0;
      in_acc = 1'b0;
    end
  end

  // Counting stream and write-order tracker for the default instance
  int unsigned d_idx = 0;
  int d_nw = 0, d_bad = 0, d_ndone = 0;
  logic [12:0] d_last_a = '0, d_ea;
  logic [31:0] d_last_d = '0, d_ed;
  logic d_hs;

  assign d_s_data = d_idx;

  always begin
    @(negedge HCLK);
    d_hs = d_s_valid_hs();
    if (d_psel && d_penable) begin
      if (d_nw == 0) begin
        d_ea = 13'd0;
        d_ed = 32'd1;
      end else begin
        d_ea = (d_nw <= 9) ? 13'd1 : 13'd2;
        d_ed = d_nw - 1;
      end
      if (d_paddr !== d_ea || d_pwdata !== d_ed) d_bad++;
      d_last_a = d_paddr;
      d_last_d = d_pwdata;
      d_nw++;
    end
    if (d_done) d_ndone++;
    @(posedge HCLK);
    #1;
    if (d_hs && !HRESET) d_idx++;
  end

  function automatic logic d_s_valid_hs();
    return d_s_ready;
  endfunction

  int full_a [6] = '{0, 1, 1, 2, 2, 2};
  int full_d [6] = '{1, 'h11, 'h22, 'h33, 'h44, 'h55};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_count"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(full_a[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(full_d[i]));
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    sidx = 0;
    gap = 0;
    unstable = 0;
    wait_cycles = 0;
    hold_cycles = 0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = 0;
    do begin
      @(posedge HCLK);
      #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < bound);
  endtask

  task automatic run_job(input int bound, output int lat);
    @(posedge HCLK);
    #1;
    start = 1'b1;
    wait_done(bound, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    int lat;
    int n;

    // Reset values
    idle(2);
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_pwrite", 64'(pwrite), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_d_psel", 64'(d_psel), 64'(0));
    check("rst_d_busy", 64'(d_busy), 64'(0));
    HRESET = 1'b0;
    idle(2);

    // Basic job: zero-wait slave, stream always valid
    clear_mon();
    run_job(200, lat);
    check("basic_latency", 64'(lat), 64'(18));
    check("basic_err", 64'(err), 64'(0));
    idle(1);
    check("basic_busy_after", 64'(busy), 64'(0));
    check("basic_done_after", 64'(done), 64'(0));
    check_writes("basic", 6);

    // Two wait states on every ACCESS
    clear_mon();
    ws_mode = 1'b1;
    run_job(200, lat);
    ws_mode = 1'b0;
    check("ws_latency", 64'(lat), 64'(30));
    check("ws_wait_cycles", 64'(wait_cycles), 64'(12));
    check("ws_stable", 64'(unstable), 64'(0));
    idle(2);
    check_writes("ws", 6);

    // Stream starvation before word 3
    clear_mon();
    starve = 1'b1;
    run_job(200, lat);
    starve = 1'b0;
    check("starve_latency", 64'(lat), 64'(21));
    check("starve_hold_cycles", 64'(hold_cycles), 64'(3));
    idle(2);
    check_writes("starve", 6);

    // Slave error on the second A write
    clear_mon();
    slverr_en = 1'b1;
    run_job(200, lat);
    check("slverr_latency", 64'(lat), 64'(9));
    check("slverr_err_at_done", 64'(err), 64'(1));
    idle(5);
    slverr_en = 1'b0;
    check("slverr_err_sticky", 64'(err), 64'(1));
    check("slverr_s_ready", 64'(s_ready), 64'(0));
    check("slverr_psel", 64'(psel), 64'(0));
    check("slverr_consumed", 64'(sidx), 64'(2));
    check_writes("slverr", 3);

    // Next start clears err
    clear_mon();
    @(posedge HCLK);
    #1;
    start = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    check("restart_err_cleared", 64'(err), 64'(0));
    check("restart_busy", 64'(busy), 64'(1));
    wait_done(200, lat);
    check("restart_latency", 64'(lat), 64'(17));
    check("restart_err", 64'(err), 64'(0));
    idle(2);
    check_writes("restart", 6);

    // Asynchronous reset during an X ACCESS
    clear_mon();
    @(posedge HCLK);
    #1;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge HCLK);
      #1;
      start = 1'b0;
      n++;
    end while (!(psel && penable && paddr == 13'd2) && n < 100);
    check("rst_mid_found_x_access", 64'(psel && penable && paddr == 13'd2), 64'(1));
    #2;
    HRESET = 1'b1;
    #1;
    check("rst_mid_psel", 64'(psel), 64'(0));
    check("rst_mid_penable", 64'(penable), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_pwrite", 64'(pwrite), 64'(0));
    check("rst_mid_paddr", 64'(paddr), 64'(0));
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    idle(2);
    clear_mon();
    run_job(200, lat);
    check("post_rst_latency", 64'(lat), 64'(18));
    idle(2);
    check_writes("post_rst", 6);

    check("no_back_to_back_setup", 64'(b2b), 64'(0));

    // Default sizes, counting stream, start pulsed while busy
    @(posedge HCLK);
    #1;
    d_start = 1'b1;
    lat = 0;
    do begin
      @(posedge HCLK);
      #1;
      lat++;
      d_start = (lat == 100);
    end while (!d_done && lat < 3000);
    d_start = 1'b0;
    check("dflt_latency", 64'(lat), 64'(2382));
    check("dflt_err", 64'(d_err), 64'(0));
    idle(5);
    check("dflt_writes", 64'(d_nw), 64'(794));
    check("dflt_order_errors", 64'(d_bad), 64'(0));
    check("dflt_last_addr", 64'(d_last_a), 64'(2));
    check("dflt_last_data", 64'(d_last_d), 64'(792));
    check("dflt_done_pulses", 64'(d_ndone), 64'(1));
    check("dflt_busy_after", 64'(d_busy), 64'(0));
    check("dflt_words_consumed", 64'(d_idx), 64'(793));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
